// File: rtl/nand_chain_pkg.sv
// Shared types and constants for the NAND-chain arbiter slice.
package nand_chain_pkg;

    localparam int unsigned EFG_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StResp
    } state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } operand_t;

endpackage

// File: rtl/nand_chain_arbiter_if.sv
// Request/grant/response bundle between stimulus sources and the shared NAND chain.
interface nand_chain_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    import nand_chain_pkg::*;

    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [EFG_W-1:0]  rsp_efg;

    modport master (
        output req, req_data,
        input  grant, busy, rsp_valid, rsp_id, rsp_efg
    );

    modport slave (
        input  req, req_data,
        output grant, busy, rsp_valid, rsp_id, rsp_efg
    );

endinterface

// File: rtl/nand_chain_core.sv
// Combinational four-input NAND chain: e=~(a&b), f=~(e&c), g=~(f&d).
module nand_chain_core
    import nand_chain_pkg::*;
(
    input  operand_t         i_op,
    output logic [EFG_W-1:0] o_efg
);

    logic w_e;
    logic w_f;
    logic w_g;

    assign w_e   = ~(i_op.a & i_op.b);
    assign w_f   = ~(w_e & i_op.c);
    assign w_g   = ~(w_f & i_op.d);
    assign o_efg = {w_e, w_f, w_g};

endmodule

// File: rtl/nand_chain_arbiter.sv
// Round-robin arbiter sharing one NAND chain; operands latched on grant, result
// captured after a settle window and returned with the requester id.
module nand_chain_arbiter
    import nand_chain_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nand_chain_arbiter_if.slave bus
);

    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (SETTLE < 1) begin : g_settle_chk
        $error("nand_chain_arbiter: SETTLE must be >= 1");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
        $error("nand_chain_arbiter: NREQ must be in 2..8");
    end

    state_e           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_idx;
    logic [CNT_W-1:0] r_cnt;
    operand_t         r_op;
    logic [NREQ-1:0]  r_grant;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [EFG_W-1:0] r_rsp_efg;

    logic [IDW-1:0]   w_pick;
    operand_t         w_pick_op;
    logic [EFG_W-1:0] w_efg;

    // First set request at or after ptr, wrapping; scanning downwards lets the
    // nearest candidate overwrite the farther ones.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        pick = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % int'(NREQ));
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        w_pick    = rr_pick(bus.req, r_ptr);
        w_pick_op = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDW'(i) == w_pick) w_pick_op = bus.req_data[4*i +: 4];
        end
    end

    nand_chain_core u_core (
        .i_op  (r_op),
        .o_efg (w_efg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_efg   <= '0;
        end else begin
            r_grant     <= '0;
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (|bus.req) begin
                        r_grant <= NREQ'(1) << w_pick;
                        r_op    <= w_pick_op;
                        r_idx   <= w_pick;
                        r_cnt   <= CNT_W'(SETTLE - 1);
                        r_busy  <= 1'b1;
                        r_state <= StEval;
                    end
                end
                StEval: begin
                    // The grant cycle is the operand-sample cycle; the settle
                    // window counts from the cycle after it.
                    if (r_grant == '0) begin
                        if (r_cnt == '0) begin
                            r_rsp_efg   <= w_efg;
                            r_rsp_id    <= r_idx;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                StResp: begin
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_idx == IDW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_efg   = r_rsp_efg;

endmodule

// File: tb/tb_nand_chain_arbiter.sv
// Directed bench for nand_chain_arbiter: single-service vector table plus
// hand-written reset, operand-hold, round-robin, wrap and withdraw sequences.
module tb_nand_chain_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned SETTLE = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    nand_chain_arbiter_if #(.NREQ(NREQ)) bus ();

    nand_chain_arbiter #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] data;
        logic [2:0] efg;
    } vec_t;

    vec_t vecs [6];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   onehot_err = 0;
    int   cyc, lat, nrsp, ngnt;
    logic [4*NREQ-1:0] rd;

    always @(negedge clk) begin
        if ((bus.grant & (bus.grant - 4'd1)) != 4'd0) onehot_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (bus.grant == '0 && c < 40);
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        do begin
            tick();
            l++;
        end while (!bus.rsp_valid && l < 40);
    endtask

    task automatic do_service(input int id, input logic [3:0] data, input logic [2:0] efg,
                              input string tag);
        logic [4*NREQ-1:0] v;
        int c, l;
        v             = {NREQ{4'hA}};
        v[4*id +: 4]  = data;
        bus.req_data  = v;
        bus.req       = NREQ'(1) << id;
        wait_grant(c);
        chk({tag, " grant"}, 32'(bus.grant), 32'(4'b0001 << id));
        bus.req = '0;
        wait_rsp(l);
        chk({tag, " latency"}, 32'(l), 32'(SETTLE + 1));
        chk({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(id));
        chk({tag, " rsp_efg"}, 32'(bus.rsp_efg), 32'(efg));
        tick();
        chk({tag, " back to idle"}, 32'({bus.busy, bus.rsp_valid, bus.grant}), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        vecs[0] = '{0, 4'b1111, 3'b010};
        vecs[1] = '{1, 4'b0000, 3'b111};
        vecs[2] = '{3, 4'b1110, 3'b011};
        vecs[3] = '{2, 4'b0101, 3'b110};
        vecs[4] = '{0, 4'b1011, 3'b101};
        vecs[5] = '{1, 4'b1100, 3'b011};

        #2 reset_n = 1'b0;
        repeat (3) tick();
        chk("reset outputs",
            32'({bus.grant, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_efg}), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_service(vecs[i].id, vecs[i].data, vecs[i].efg, $sformatf("vec%0d", i));
        end

        // Operand hold: data changes during EVAL must not reach the result.
        rd           = {NREQ{4'hA}};
        rd[11:8]     = 4'b0111;
        bus.req_data = rd;
        bus.req      = 4'b0100;
        wait_grant(cyc);
        chk("hold grant", 32'(bus.grant), 32'(4'b0100));
        bus.req = '0;
        tick();
        rd[11:8]     = 4'b1111;
        bus.req_data = rd;
        wait_rsp(lat);
        chk("hold rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold rsp_id", 32'(bus.rsp_id), 32'd2);
        chk("hold rsp_efg", 32'(bus.rsp_efg), 32'(3'b101));
        tick();

        // Reset mid-EVAL with a non-zero pointer and stale response fields.
        do_service(1, 4'b0000, 3'b111, "pre-reset");
        bus.req_data = '0;
        bus.req      = 4'b0100;
        wait_grant(cyc);
        chk("rst grant", 32'(bus.grant), 32'(4'b0100));
        bus.req = '0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst async outputs",
            32'({bus.grant, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_efg}), 32'd0);
        tick();
        reset_n = 1'b1;
        nrsp = 0;
        repeat (SETTLE + 4) begin
            tick();
            if (bus.rsp_valid) nrsp++;
        end
        chk("rst dropped rsp", 32'(nrsp), 32'd0);
        bus.req = 4'b1010;
        wait_grant(cyc);
        chk("rst ptr0 grant", 32'(bus.grant), 32'(4'b0010));
        bus.req = 4'b1000;
        wait_grant(cyc);
        chk("rst next grant", 32'(bus.grant), 32'(4'b1000));
        chk("rst next gap", 32'(cyc), 32'(SETTLE + 3));
        bus.req = '0;
        wait_rsp(lat);
        tick();

        // Round robin with all requests held continuously.
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(cyc);
            chk($sformatf("rr grant%0d", k), 32'(bus.grant), 32'(4'b0001 << (k % 4)));
            if (k > 0) chk($sformatf("rr gap%0d", k), 32'(cyc), 32'(SETTLE + 3));
        end
        bus.req = '0;
        wait_rsp(lat);
        tick();

        // Wrap: pointer at 3, requests 0 and 2.
        do_service(2, 4'b0101, 3'b110, "pre-wrap");
        bus.req = 4'b0101;
        wait_grant(cyc);
        chk("wrap first", 32'(bus.grant), 32'(4'b0001));
        bus.req = 4'b0100;
        wait_grant(cyc);
        chk("wrap second", 32'(bus.grant), 32'(4'b0100));
        bus.req = '0;
        wait_rsp(lat);
        tick();
        bus.req = 4'b1001;
        wait_grant(cyc);
        chk("wrap ptr3", 32'(bus.grant), 32'(4'b1000));
        bus.req = '0;
        wait_rsp(lat);
        tick();

        // Withdraw: a one-cycle request during EVAL is never granted.
        bus.req = 4'b0001;
        wait_grant(cyc);
        chk("wd grant0", 32'(bus.grant), 32'(4'b0001));
        bus.req = '0;
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        ngnt = 0;
        nrsp = 0;
        repeat (10) begin
            tick();
            if (|bus.grant) ngnt++;
            if (bus.rsp_valid) nrsp++;
        end
        chk("wd no grant", 32'(ngnt), 32'd0);
        chk("wd one rsp", 32'(nrsp), 32'd1);
        chk("wd idle", 32'({bus.grant, bus.busy}), 32'd0);

        chk("grant one-hot", 32'(onehot_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
